// File: rtl/proc_csr_io_unit.sv
// CSR I/O unit: NCH input capture buffers and NCH output FIFOs behind csrr/csrw,
// with a D-stage stall when an access cannot complete and a registered X-stage read result.
module proc_csr_io_unit #(
   parameter int          NCH          = 3,
   parameter int          W            = 32,
   parameter int          OUT_DEPTH    = 2,
   parameter logic [11:0] IN_CSR_BASE  = 12'hFC2,
   parameter logic [11:0] OUT_CSR_BASE = 12'h7C2,
   parameter logic [11:0] STAT_CSR     = 12'hFC0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             csrr_en_D,
   input  logic [11:0]      csrr_addr_D,
   input  logic             csrw_en_D,
   input  logic [11:0]      csrw_addr_D,
   input  logic [W-1:0]     csrw_data_D,
   output logic             stall_D,
   output logic [W-1:0]     csrr_data_X,
   input  logic [NCH*W-1:0] in_data,
   input  logic [NCH-1:0]   in_val,
   output logic [NCH-1:0]   in_rdy,
   output logic [NCH*W-1:0] out_data,
   output logic [NCH-1:0]   out_val,
   input  logic [NCH-1:0]   out_rdy
);

   localparam int             PW       = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
   localparam int             CW       = $clog2(OUT_DEPTH + 1);
   localparam logic [CW-1:0]  FULL_CNT = CW'(OUT_DEPTH);
   localparam logic [PW-1:0]  LAST_PTR = PW'(OUT_DEPTH - 1);

   logic [NCH-1:0] in_full;
   logic [W-1:0]   in_buf   [NCH];
   logic [W-1:0]   fifo_mem [NCH][OUT_DEPTH];
   logic [PW-1:0]  head     [NCH];
   logic [PW-1:0]  tail     [NCH];
   logic [CW-1:0]  count    [NCH];

   logic [NCH-1:0] out_full;
   logic [NCH-1:0] rd_sel, wr_sel;
   logic [NCH-1:0] in_cap, in_take, out_enq, out_deq;
   logic           rd_stat, rd_stall, wr_stall;
   logic [W-1:0]   rd_data;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PW'(1);
   endfunction

   // Address decode; indices at or beyond NCH never match, so they read as unmapped.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no latch is inferred.
      rd_sel = '0;
      wr_sel = '0;
      for (int i = 0; i < NCH; i++) begin
         rd_sel[i] = csrr_en_D && (csrr_addr_D == 12'(IN_CSR_BASE + i));
         wr_sel[i] = csrw_en_D && (csrw_addr_D == 12'(OUT_CSR_BASE + i));
      end
      rd_stat = csrr_en_D && (csrr_addr_D == STAT_CSR);
   end

   always_comb begin
      out_data = '0;
      for (int i = 0; i < NCH; i++) begin
         out_val[i]  = (count[i] != '0);
         out_full[i] = (count[i] == FULL_CNT);
         if (out_val[i]) out_data[i*W +: W] = fifo_mem[i][head[i]];
      end
   end

   assign rd_stall = |(rd_sel & ~in_full);
   assign wr_stall = |(wr_sel & out_full);
   assign stall_D  = rd_stall | wr_stall;

   // A stall blocks both accesses, so the retried instruction sees an unchanged unit.
   assign in_rdy  = ~in_full;
   assign in_cap  = in_val & ~in_full;
   assign in_take = rd_sel & in_full & {NCH{!stall_D}};
   assign out_enq = wr_sel & ~out_full & {NCH{!stall_D}};
   assign out_deq = out_val & out_rdy;

   always_comb begin
      rd_data = '0;
      if (!stall_D) begin
         for (int i = 0; i < NCH; i++)
            if (rd_sel[i]) rd_data = in_buf[i];
         if (rd_stat) rd_data = W'({out_full, in_full});
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         in_full     <= '0;
         csrr_data_X <= '0;
         for (int i = 0; i < NCH; i++) begin
            head[i]  <= '0;
            tail[i]  <= '0;
            count[i] <= '0;
         end
      end else begin
         csrr_data_X <= rd_data;
         for (int i = 0; i < NCH; i++) begin
            if (in_cap[i])       in_full[i] <= 1'b1;
            else if (in_take[i]) in_full[i] <= 1'b0;
            if (out_enq[i]) tail[i] <= ptr_inc(tail[i]);
            if (out_deq[i]) head[i] <= ptr_inc(head[i]);
            case ({out_enq[i], out_deq[i]})
               2'b10:   count[i] <= count[i] + CW'(1);
               2'b01:   count[i] <= count[i] - CW'(1);
               default: count[i] <= count[i];
            endcase
         end
      end
   end

   // NOTE: data storage is not reset; the valid flags and counts above decide what is visible.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NCH; i++) begin
         if (in_cap[i])  in_buf[i]            <= in_data[i*W +: W];
         if (out_enq[i]) fifo_mem[i][tail[i]] <= csrw_data_D;
      end
   end

endmodule

// File: doc/proc_csr_io_unit.md
Name: proc_csr_io_unit

Overview:
- Parametrised CSR I/O unit replacing the fixed three-input/three-output CSR registers in the processor datapath.
- Provides NCH input channels, each with a val/rdy capture buffer, and NCH output channels, each with an OUT_DEPTH-entry FIFO and val/rdy drain.
- Decode stage issues csrr/csrw in D; read data is registered into X with 1-cycle latency, matching the existing csrr D->X register timing.
- Produces stall_D back-pressure to the control unit when a CSR access cannot complete.

Parameters:
- NCH, 3, number of input and of output channels (1..8).
- W, 32, channel data width (≥ 2*NCH).
- OUT_DEPTH, 2, output FIFO entries per channel (power of 2, ≥1).
- IN_CSR_BASE, 12'hFC2, CSR address of input channel 0; channel i at base+i.
- OUT_CSR_BASE, 12'h7C2, CSR address of output channel 0; channel i at base+i.
- STAT_CSR, 12'hFC0, read-only status CSR address.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- csrr_en_D  in  1  csrr in D (already squash-gated by control)
- csrr_addr_D  in  12  csrr CSR number
- csrw_en_D  in  1  csrw in D (already squash-gated)
- csrw_addr_D  in  12  csrw CSR number
- csrw_data_D  in  W  bypassed rs1 value
- stall_D  out  1  combinational; access cannot complete this cycle
- csrr_data_X  out  W  registered read result
- in_data  in  NCH*W  input channel data, channel i at [i*W +: W]
- in_val  in  NCH  input valid per channel
- in_rdy  out  NCH  input ready per channel
- out_data  out  NCH*W  output FIFO head per channel
- out_val  out  NCH  output valid per channel
- out_rdy  in  NCH  output ready per channel

Behaviour:
- Reset: all in buffers empty (in_rdy = all 1s), all out FIFOs empty (out_val = 0, out_data = 0), csrr_data_X = 0. Reset asserted mid-operation discards all buffered data immediately.
- Input channel i: 1-entry buffer, in_rdy[i] = !full_i.
  - Capture on in_val[i] && in_rdy[i]; buffer is full next cycle.
  - No pass-through: a full buffer deasserts in_rdy even in the cycle it is consumed.
- csrr to IN_CSR_BASE+i:
  - Buffer full: stall_D = 0, value loaded into csrr_data_X at the next edge, buffer cleared.
  - Buffer empty: stall_D = 1, no side effect.
- csrr to STAT_CSR: never stalls.
  - Returns {out_full[NCH-1:0], in_full[NCH-1:0]} zero-extended; in_full occupies bits [NCH-1:0].
- csrr to an unmapped address, or csrr_en_D = 0: csrr_data_X loads 0.
- Output channel i: circular FIFO with head/tail pointers and count, pointers wrapping modulo OUT_DEPTH.
  - out_val[i] = count != 0.
  - out_data is the head entry, or 0 when empty.
  - Dequeue on out_val && out_rdy.
- csrw to OUT_CSR_BASE+i:
  - count < OUT_DEPTH: enqueue csrw_data_D[W-1:0], stall_D = 0.
  - count == OUT_DEPTH: stall_D = 1 and no enqueue, even if a dequeue occurs the same cycle (no full-bypass).
  - Simultaneous enqueue and dequeue when not full: count unchanged.
- csrw to an input or status CSR, or to an unmapped address: ignored, no stall.
- stall_D = read-stall | write-stall.
  - When stall_D = 1, neither access has side effects and csrr_data_X loads 0.
  - Control holds D and retries next cycle.
- csrr and csrw in the same cycle are evaluated independently, subject to the stall rule above.
- Out-of-range channel index (base+i with i ≥ NCH) is treated as unmapped.

Test Plan:
- Reset, then idle 3 cycles -> in_rdy = 3'b111, out_val = 0, csrr_data_X = 0, stall_D = 0.
- in_val[1] = 1, in_data ch1 = 32'h0000_00AB for 1 cycle; csrr 0xFC3 next cycle -> stall_D = 0, csrr_data_X = 0xAB one cycle later, in_rdy[1] returns to 1.
- csrr 0xFC2 with ch0 empty -> stall_D = 1 and csrr_data_X = 0. Then assert in_val[0] with 32'h55 -> the following cycle stall_D = 0 and csrr_data_X = 0x55 after one more edge.
- out_rdy = 0; csrw 0x7C2 with 1, then 2, then 3 -> first two accepted; third gives stall_D = 1 until out_rdy = 1. out_data sequence is 1, 2, 3, FIFO order preserved across pointer wrap.
- Ch2 FIFO full with out_rdy = 1 and a csrw in the same cycle -> stall_D = 1, count drops to 1; retry next cycle accepted.
- Fill in ch0 and out ch1 (both entries), then csrr 0xFC0 -> csrr_data_X = 32'h0000_0011. Assert rst mid-stream -> all buffers empty immediately.
